// File: rtl/sk9822_axil_regs_if.sv
// AXI4-Lite slave bus carrying the SK9822 register block's five channels.
interface sk9822_axil_regs_if #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [2:0]                      S_AXI_AWPROT;
   logic                            S_AXI_AWVALID;
   logic                            S_AXI_AWREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                            S_AXI_WVALID;
   logic                            S_AXI_WREADY;
   logic [1:0]                      S_AXI_BRESP;
   logic                            S_AXI_BVALID;
   logic                            S_AXI_BREADY;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [2:0]                      S_AXI_ARPROT;
   logic                            S_AXI_ARVALID;
   logic                            S_AXI_ARREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]                      S_AXI_RRESP;
   logic                            S_AXI_RVALID;
   logic                            S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY
   );
endinterface

// File: rtl/sk9822_axil_regs.sv
// Four AXI4-Lite read/write registers feeding the SK9822 frame engine.
// Define SK9822_AXIL_WSTRB_EN to honour WSTRB byte lanes; otherwise writes replace the full word.
module sk9822_axil_regs #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   sk9822_axil_regs_if.slave             s_axi,
   output logic [C_S_AXI_DATA_WIDTH-1:0] REG0,
   output logic [C_S_AXI_DATA_WIDTH-1:0] REG1,
   output logic [C_S_AXI_DATA_WIDTH-1:0] REG2,
   output logic [C_S_AXI_DATA_WIDTH-1:0] REG3,
   output logic [3:0]                    REG_WR_PULSE
);
   localparam int unsigned DW = C_S_AXI_DATA_WIDTH;

   typedef enum logic [1:0] {W_IDLE, W_WAIT_AW, W_WAIT_W, W_RESP} wstate_e;
   typedef enum logic {R_IDLE, R_DATA} rstate_e;

   wstate_e         wstate_q;
   rstate_e         rstate_q;
   logic [DW-1:0]   regs_q [4];
   logic [1:0]      waddr_q;
   logic [DW-1:0]   wdata_q;
   logic            awready_q, wready_q, bvalid_q;
   logic            arready_q, rvalid_q;
   logic [DW-1:0]   rdata_q;
   logic [3:0]      pulse_q;

   logic            aw_hs, w_hs, wr_en;
   logic [1:0]      wr_idx;
   logic [DW-1:0]   wr_data, wr_word;
`ifdef SK9822_AXIL_WSTRB_EN
   logic [DW/8-1:0] wstrb_q;
   logic [DW/8-1:0] wr_strb;
`endif

   // The second of AW/W to arrive supplies its field live; the first comes from the latches.
   always_comb begin
      aw_hs   = s_axi.S_AXI_AWVALID && awready_q;
      w_hs    = s_axi.S_AXI_WVALID && wready_q;
      wr_idx  = aw_hs ? s_axi.S_AXI_AWADDR[3:2] : waddr_q;
      wr_data = w_hs ? s_axi.S_AXI_WDATA : wdata_q;
      wr_en   = 1'b0;
      case (wstate_q)
         W_IDLE:    wr_en = aw_hs && w_hs;
         W_WAIT_W:  wr_en = w_hs;
         W_WAIT_AW: wr_en = aw_hs;
         default:   wr_en = 1'b0;
      endcase
`ifdef SK9822_AXIL_WSTRB_EN
      wr_strb = w_hs ? s_axi.S_AXI_WSTRB : wstrb_q;
      wr_word = regs_q[wr_idx];
      for (int b = 0; b < DW / 8; b++) begin
         if (wr_strb[b]) wr_word[8*b +: 8] = wr_data[8*b +: 8];
      end
`else
      wr_word = wr_data;
`endif
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         pulse_q   <= '0;
         for (int i = 0; i < 4; i++) regs_q[i] <= '0;
`ifdef SK9822_AXIL_WSTRB_EN
         wstrb_q   <= '0;
`endif
      end else begin
         pulse_q <= '0;
         if (wr_en) begin
            regs_q[wr_idx] <= wr_word;
            pulse_q        <= 4'b0001 << wr_idx;
            awready_q      <= 1'b0;
            wready_q       <= 1'b0;
            bvalid_q       <= 1'b1;
            wstate_q       <= W_RESP;
         end else begin
            case (wstate_q)
               W_IDLE: begin
                  if (aw_hs) begin
                     waddr_q   <= s_axi.S_AXI_AWADDR[3:2];
                     awready_q <= 1'b0;
                     wstate_q  <= W_WAIT_W;
                  end else if (w_hs) begin
                     wdata_q   <= s_axi.S_AXI_WDATA;
`ifdef SK9822_AXIL_WSTRB_EN
                     wstrb_q   <= s_axi.S_AXI_WSTRB;
`endif
                     wready_q  <= 1'b0;
                     wstate_q  <= W_WAIT_AW;
                  end else begin
                     awready_q <= 1'b1;
                     wready_q  <= 1'b1;
                  end
               end
               W_RESP: begin
                  if (s_axi.S_AXI_BREADY) begin
                     bvalid_q  <= 1'b0;
                     awready_q <= 1'b1;
                     wready_q  <= 1'b1;
                     wstate_q  <= W_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Capturing regs_q on the AR edge returns the pre-write value on a same-cycle write.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               if (s_axi.S_AXI_ARVALID && arready_q) begin
                  rdata_q   <= regs_q[s_axi.S_AXI_ARADDR[3:2]];
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
                  rstate_q  <= R_DATA;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_axi.S_AXI_RREADY) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  rstate_q  <= R_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   assign s_axi.S_AXI_AWREADY = awready_q;
   assign s_axi.S_AXI_WREADY  = wready_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = 2'b00;
   assign s_axi.S_AXI_ARREADY = arready_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = 2'b00;

   assign REG0         = regs_q[0];
   assign REG1         = regs_q[1];
   assign REG2         = regs_q[2];
   assign REG3         = regs_q[3];
   assign REG_WR_PULSE = pulse_q;

   logic unused_bits;
   assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
`ifndef SK9822_AXIL_WSTRB_EN
                          s_axi.S_AXI_WSTRB,
`endif
                          s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};
endmodule

// File: doc/sk9822_axil_regs.md
SK9822_AXIL_REGS -- requirements
Module: sk9822_axil_regs

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, giving the data bus width; only 32 is supported.
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, giving the byte address width, which decodes 4 word registers.
REQ-003 The block SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port ARESETN, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have the AXI4-Lite write address ports: S_AXI_AWADDR in [ADDR_W]; S_AXI_AWPROT in [3] (ignored); S_AXI_AWVALID in [1]; S_AXI_AWREADY out [1].
REQ-006 The block SHALL have the write data ports: S_AXI_WDATA in [32]; S_AXI_WSTRB in [4]; S_AXI_WVALID in [1]; S_AXI_WREADY out [1].
REQ-007 The block SHALL have the write response ports: S_AXI_BRESP out [2]; S_AXI_BVALID out [1]; S_AXI_BREADY in [1].
REQ-008 The block SHALL have the read address ports: S_AXI_ARADDR in [ADDR_W]; S_AXI_ARPROT in [3] (ignored); S_AXI_ARVALID in [1]; S_AXI_ARREADY out [1].
REQ-009 The block SHALL have the read data ports: S_AXI_RDATA out [32]; S_AXI_RRESP out [2]; S_AXI_RVALID out [1]; S_AXI_RREADY in [1].
REQ-010 The block SHALL have port REG0..REG3, output, 32 bits each: current register contents, driven to the SK9822 frame engine.
REQ-011 The block SHALL have port REG_WR_PULSE, output, 4 bits: bit n is high for one cycle after register n is written.

Function
REQ-012 Register index SHALL be AWADDR[3:2] / ARADDR[3:2]; bits [1:0] SHALL be ignored; all four registers SHALL be read/write.
REQ-013 The write FSM SHALL have states W_IDLE, W_WAIT_AW, W_WAIT_W and W_RESP.
- W_IDLE: AWREADY=1, WREADY=1.
- If AW and W handshake in the same cycle, go to W_RESP.
- If only AW handshakes, latch the address and go to W_WAIT_W (WREADY=1, AWREADY=0).
- If only W handshakes, latch data/strobe and go to W_WAIT_AW (AWREADY=1, WREADY=0).
REQ-014 The register update SHALL occur on the clock edge where the second of AW/W completes; REG_WR_PULSE SHALL assert on the following cycle for one cycle.
REQ-015 W_RESP SHALL hold BVALID=1 and BRESP=OKAY(00) until BREADY, then return to W_IDLE; AWREADY and WREADY SHALL be 0 while in W_RESP.
REQ-016 Write latency (last of AW/W accepted to BVALID) SHALL be exactly 1 cycle.
REQ-017 The read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA.
- On the AR handshake, capture the addressed register into RDATA and go to R_DATA.
- R_DATA: RVALID=1, RRESP=00, RDATA stable until RREADY, then R_IDLE.
- Read latency SHALL be 1 cycle.
REQ-018 Read and write FSMs SHALL be independent; simultaneous read and write of the same register SHALL return the pre-write value.
REQ-019 Back-to-back transactions SHALL be accepted one cycle after the BREADY or RREADY handshake (one idle cycle of READY=1 minimum).
REQ-020 VALID outputs SHALL never depend combinationally on READY inputs.

Reset
REQ-021 On ARESETN low, outputs SHALL immediately take these values: REG0..REG3=0, REG_WR_PULSE=0, BVALID=0, RVALID=0, BRESP=00, RRESP=00, RDATA=0, AWREADY=0, WREADY=0, ARREADY=0.
REQ-022 On ARESETN low, both FSMs SHALL go to IDLE and latched address/data SHALL be discarded; a transaction in flight SHALL be dropped with no response.
REQ-023 READY signals SHALL assert on the first rising edge after ARESETN deasserts.

Configuration
REQ-024 With macro SK9822_AXIL_WSTRB_EN defined, a write SHALL update only the byte lanes whose WSTRB bit is 1; WSTRB=0000 SHALL leave the register unchanged but still pulse REG_WR_PULSE and return OKAY.
REQ-025 With SK9822_AXIL_WSTRB_EN undefined, WSTRB SHALL be ignored and every write SHALL replace the full 32-bit word.

Verification
REQ-026 Write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, then read them back -> each read returns the written value with RRESP=00, and REG0..3 show 1..4.
REQ-027 Present AW at addr 0x8 three cycles before W data 0xA5A5A5A5 -> the FSM passes through W_WAIT_W, REG2=0xA5A5A5A5, REG_WR_PULSE=0100 for 1 cycle, BVALID 1 cycle after the W handshake.
REQ-028 Hold BREADY=0 for 5 cycles after a write -> BVALID stays 1, AWREADY and WREADY stay 0, and the next write is accepted only after BREADY.
REQ-029 With SK9822_AXIL_WSTRB_EN, REG1=0x11223344, write 0xFFFFFFFF with WSTRB=0101 -> REG1=0x11FF33FF; without the macro -> REG1=0xFFFFFFFF.
REQ-030 Assert ARESETN low while RVALID=1 and REG0=0x5 -> RVALID=0 and REG0=0 immediately without a clock edge; the next read of 0x0 returns 0.
REQ-031 Issue AR 0x4 and AW/W 0x4 = 0x77 in the same cycle with REG1=0x2 -> RDATA=0x2 and REG1=0x77 afterwards.
